// File: rtl/imem_dmem_arbiter.sv
// Shares one single-ported memory between instruction fetch and data load/store.
// Optional performance counters are compiled in when ARB_PERF_CNT_EN is defined.
module imem_dmem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int LAT        = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req_valid,
  output logic            if_req_ready,
  input  logic [AW-1:0]   if_addr,
  input  logic            if_flush,
  output logic            if_resp_valid,
  output logic [DW-1:0]   if_rdata,
  input  logic            d_req_valid,
  output logic            d_req_ready,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_wmask,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_resp_valid,
  output logic [DW-1:0]   d_rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_wmask,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]     perf_if_grants,
  output logic [31:0]     perf_d_grants,
  output logic [31:0]     perf_conflicts
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t     state;
  logic       owner_d;
  logic       we_q;
  logic       cancel;
  logic       if_resp_q;
  logic [1:0] lat_cnt;
  logic [3:0] starve_cnt;
  logic       idle;
  logic       starved;
  logic       grant_d;
  logic       grant_if;

  // Data wins ties unless fetch has already waited through STARVE_MAX data grants.
  always_comb begin
    idle     = (state == IDLE) && !rst;
    starved  = (starve_cnt == 4'(STARVE_MAX));
    grant_d  = idle && d_req_valid && !(if_req_valid && starved);
    grant_if = idle && if_req_valid && !grant_d;
  end

  assign d_req_ready  = grant_d;
  assign if_req_ready = grant_if;
  // A flush landing in the response cycle itself still squashes the pulse.
  assign if_resp_valid = if_resp_q && !if_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      owner_d      <= 1'b0;
      we_q         <= 1'b0;
      cancel       <= 1'b0;
      if_resp_q    <= 1'b0;
      lat_cnt      <= '0;
      starve_cnt   <= '0;
      if_rdata     <= '0;
      d_resp_valid <= 1'b0;
      d_rdata      <= '0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_wmask    <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d || grant_if) begin
            owner_d   <= grant_d;
            we_q      <= grant_d && d_we;
            cancel    <= grant_if && if_flush;
            mem_en    <= 1'b1;
            mem_we    <= grant_d && d_we;
            mem_wmask <= grant_d ? d_wmask : '0;
            mem_addr  <= grant_d ? d_addr : if_addr;
            mem_wdata <= grant_d ? d_wdata : '0;
            if (grant_if)
              starve_cnt <= '0;
            else if (if_req_valid && !starved)
              starve_cnt <= starve_cnt + 4'd1;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          mem_en    <= 1'b0;
          mem_we    <= 1'b0;
          mem_wmask <= '0;
          lat_cnt   <= 2'(LAT - 1);
          if (!owner_d && if_flush)
            cancel <= 1'b1;
          state <= WAIT;
        end
        WAIT: begin
          if (!owner_d && if_flush)
            cancel <= 1'b1;
          if (lat_cnt == 2'd0) begin
            state <= RESP;
            if (owner_d) begin
              d_resp_valid <= 1'b1;
              d_rdata      <= we_q ? '0 : mem_rdata;
            end else if (!(cancel || if_flush)) begin
              if_resp_q <= 1'b1;
              if_rdata  <= mem_rdata;
            end
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        RESP: begin
          if_resp_q    <= 1'b0;
          d_resp_valid <= 1'b0;
          cancel       <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_if_grants <= '0;
      perf_d_grants  <= '0;
      perf_conflicts <= '0;
    end else begin
      perf_if_grants <= perf_if_grants + 32'(grant_if);
      perf_d_grants  <= perf_d_grants + 32'(grant_d);
      perf_conflicts <= perf_conflicts + 32'(idle && if_req_valid && d_req_valid);
    end
  end
`endif

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Scenario bench for imem_dmem_arbiter with a behavioural memory and a response scoreboard.
module tb_imem_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LAT = 1;
  localparam int SM = 4;
  localparam int MW = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_init = 1'b1;
  logic if_req_valid = 1'b0, if_req_ready, if_flush = 1'b0, if_resp_valid;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic d_req_valid = 1'b0, d_req_ready, d_we = 1'b0, d_resp_valid;
  logic [MW-1:0] d_wmask = '0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0, d_rdata;
  logic mem_en, mem_we;
  logic [MW-1:0] mem_wmask;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_grants, perf_d_grants, perf_conflicts;
`endif

  int n_cmp = 0;
  int n_fail = 0;
  logic [DW-1:0] sb_if[$];
  logic [DW-1:0] sb_d[$];
  logic [DW-1:0] ref_mem [0:1023];
  logic [DW-1:0] tb_mem [0:1023];
  logic [DW-1:0] rd_pipe [LAT];
  logic [DW-1:0] last_if;

  always #5 clk = ~clk;

  imem_dmem_arbiter #(.AW(AW), .DW(DW), .LAT(LAT), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_flush(if_flush), .if_resp_valid(if_resp_valid), .if_rdata(if_rdata),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_we(d_we),
    .d_wmask(d_wmask), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_resp_valid(d_resp_valid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_wmask(mem_wmask), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef ARB_PERF_CNT_EN
    , .perf_if_grants(perf_if_grants), .perf_d_grants(perf_d_grants),
    .perf_conflicts(perf_conflicts)
`endif
  );

  function automatic logic [DW-1:0] init_val(int i);
    if (i == 64) return 32'h0000_0013;
    if (i == 128) return 32'h1111_2222;
    return 32'hA500_0000 | 32'(i * 7);
  endfunction

  function automatic int idx(logic [AW-1:0] a);
    return int'(a[11:2]);
  endfunction

  // Memory macro model: write on mem_en&mem_we, read data appears LAT cycles later.
  always @(posedge clk) begin : mem_model
    logic [DW-1:0] cur;
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) tb_mem[i] <= init_val(i);
    end else begin
      cur = tb_mem[mem_addr[11:2]];
      if (mem_en && mem_we) begin
        for (int b = 0; b < MW; b++)
          if (mem_wmask[b]) cur[8*b +: 8] = mem_wdata[8*b +: 8];
        tb_mem[mem_addr[11:2]] <= cur;
      end
      rd_pipe[0] <= mem_en ? cur : 32'hBADC_0DE0;
    end
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[LAT-1];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    if_req_valid = 1'b1;
    d_req_valid = 1'b1;
    #1;
    n_cmp++;
    if ({if_req_ready, d_req_ready, mem_en, mem_we, mem_wmask, if_resp_valid, d_resp_valid} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got rdy=%b%b en=%b we=%b mask=%b rv=%b%b, expected all 0",
               if_req_ready, d_req_ready, mem_en, mem_we, mem_wmask, if_resp_valid, d_resp_valid);
    end
    n_cmp++;
    if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got addr=%h wdata=%h ifr=%h dr=%h, expected all 0",
               mem_addr, mem_wdata, if_rdata, d_rdata);
    end
    if_req_valid = 1'b0;
    d_req_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    mem_init = 1'b0;
    step();
  endtask

  task automatic test_fetch_only();
    logic [DW-1:0] exp;
    step();
    if_req_valid = 1'b1;
    if_addr = 32'h100;
    #1;
    n_cmp++;
    if ({if_req_ready, d_req_ready} !== 2'b10) begin
      n_fail++; $display("FAIL fo_ready: got %b%b, expected 10", if_req_ready, d_req_ready);
    end
    sb_if.push_back(ref_mem[idx(32'h100)]);
    step();
    if_req_valid = 1'b0;
    if_addr = '0;
    #1;
    n_cmp++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100) begin
      n_fail++; $display("FAIL fo_issue: got en=%b we=%b addr=%h, expected 1 0 00000100", mem_en, mem_we, mem_addr);
    end
    step();
    #1;
    n_cmp++;
    if (mem_en !== 1'b0 || if_resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL fo_wait: got en=%b rv=%b, expected 0 0", mem_en, if_resp_valid);
    end
    step();
    #1;
    n_cmp++;
    if (if_resp_valid !== 1'b1) begin
      n_fail++; $display("FAIL fo_resp_valid: got %b, expected 1", if_resp_valid);
    end else begin
      exp = sb_if.pop_front();
      n_cmp++;
      if (if_rdata !== exp) begin
        n_fail++; $display("FAIL fo_rdata: got %h, expected %h", if_rdata, exp);
      end
      last_if = exp;
    end
    step();
    #1;
    n_cmp++;
    if (if_resp_valid !== 1'b0 || if_rdata !== 32'h13) begin
      n_fail++; $display("FAIL fo_pulse_hold: got rv=%b rdata=%h, expected 0 00000013", if_resp_valid, if_rdata);
    end
  endtask

  task automatic test_both_valid();
    logic [DW-1:0] exp;
    step();
    d_req_valid = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    if_req_valid = 1'b1; if_addr = 32'h104;
    #1;
    n_cmp++;
    if ({if_req_ready, d_req_ready} !== 2'b01) begin
      n_fail++; $display("FAIL both_prio: got if/d rdy=%b%b, expected 01", if_req_ready, d_req_ready);
    end
    sb_d.push_back(ref_mem[idx(32'h200)]);
    step();
    d_req_valid = 1'b0;
    #1;
    n_cmp++;
    if (mem_en !== 1'b1 || mem_addr !== 32'h200) begin
      n_fail++; $display("FAIL both_d_issue: got en=%b addr=%h, expected 1 00000200", mem_en, mem_addr);
    end
    step();
    #1;
    n_cmp++;
    if (mem_en !== 1'b0 || if_req_ready !== 1'b0) begin
      n_fail++; $display("FAIL both_wait: got en=%b ifrdy=%b, expected 0 0", mem_en, if_req_ready);
    end
    step();
    #1;
    n_cmp++;
    if (d_resp_valid !== 1'b1 || mem_en !== 1'b0 || if_req_ready !== 1'b0) begin
      n_fail++; $display("FAIL both_d_resp: got rv=%b en=%b ifrdy=%b, expected 1 0 0", d_resp_valid, mem_en, if_req_ready);
    end
    if (d_resp_valid === 1'b1) begin
      exp = sb_d.pop_front();
      n_cmp++;
      if (d_rdata !== exp) begin
        n_fail++; $display("FAIL both_d_rdata: got %h, expected %h", d_rdata, exp);
      end
    end
    step();
    #1;
    n_cmp++;
    if (if_req_ready !== 1'b1 || mem_en !== 1'b0) begin
      n_fail++; $display("FAIL both_if_grant_t4: got ifrdy=%b en=%b, expected 1 0", if_req_ready, mem_en);
    end
    sb_if.push_back(ref_mem[idx(32'h104)]);
    step();
    if_req_valid = 1'b0;
    #1;
    n_cmp++;
    if (mem_en !== 1'b1 || mem_addr !== 32'h104) begin
      n_fail++; $display("FAIL both_if_issue: got en=%b addr=%h, expected 1 00000104", mem_en, mem_addr);
    end
    step();
    step();
    #1;
    n_cmp++;
    if (if_resp_valid !== 1'b1) begin
      n_fail++; $display("FAIL both_if_resp: got %b, expected 1", if_resp_valid);
    end else begin
      exp = sb_if.pop_front();
      n_cmp++;
      if (if_rdata !== exp) begin
        n_fail++; $display("FAIL both_if_rdata: got %h, expected %h", if_rdata, exp);
      end
      last_if = exp;
    end
    step();
  endtask

  task automatic test_starvation();
    int g[$];
    int exp_g[6] = '{1, 1, 1, 1, 0, 1};
    logic [DW-1:0] exp;
    logic dg, fg;
    step();
    d_req_valid = 1'b1; d_we = 1'b0; d_addr = 32'h400;
    if_req_valid = 1'b1; if_addr = 32'h300;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (d_resp_valid === 1'b1) begin
        n_cmp++;
        if (sb_d.size() == 0) begin
          n_fail++; $display("FAIL starve_d_unexpected: got rdata=%h, expected no response", d_rdata);
        end else begin
          exp = sb_d.pop_front();
          if (d_rdata !== exp) begin
            n_fail++; $display("FAIL starve_d_rdata: got %h, expected %h", d_rdata, exp);
          end
        end
      end
      if (if_resp_valid === 1'b1) begin
        n_cmp++;
        if (sb_if.size() == 0) begin
          n_fail++; $display("FAIL starve_if_unexpected: got rdata=%h, expected no response", if_rdata);
        end else begin
          exp = sb_if.pop_front();
          if (if_rdata !== exp) begin
            n_fail++; $display("FAIL starve_if_rdata: got %h, expected %h", if_rdata, exp);
          end
          last_if = exp;
        end
      end
      dg = d_req_ready;
      fg = if_req_ready;
      if (dg) begin sb_d.push_back(ref_mem[idx(d_addr)]); g.push_back(1); end
      else if (fg) begin sb_if.push_back(ref_mem[idx(if_addr)]); g.push_back(0); end
      step();
      if (dg) d_addr = d_addr + 32'd4;
      if ((dg || fg) && g.size() == 6) begin
        d_req_valid = 1'b0;
        if_req_valid = 1'b0;
      end
    end
    n_cmp++;
    if (g.size() != 6) begin
      n_fail++; $display("FAIL starve_grant_count: got %0d grants, expected 6", g.size());
    end
    for (int i = 0; i < g.size() && i < 6; i++) begin
      n_cmp++;
      if (g[i] != exp_g[i]) begin
        n_fail++; $display("FAIL starve_seq[%0d]: got %0d, expected %0d (1=data 0=fetch)", i, g[i], exp_g[i]);
      end
    end
  endtask

  task automatic test_store();
    logic [DW-1:0] exp;
    step();
    d_req_valid = 1'b1; d_we = 1'b1; d_wmask = 4'b0011;
    d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF;
    #1;
    n_cmp++;
    if (d_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL st_ready: got %b, expected 1", d_req_ready);
    end
    for (int b = 0; b < MW; b++)
      if (d_wmask[b]) ref_mem[idx(d_addr)][8*b +: 8] = d_wdata[8*b +: 8];
    sb_d.push_back('0);
    step();
    d_req_valid = 1'b0; d_we = 1'b0; d_wmask = '0; d_wdata = '0;
    #1;
    n_cmp++;
    if ({mem_en, mem_we, mem_wmask} !== 6'b11_0011 || mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h200) begin
      n_fail++; $display("FAIL st_issue: got en=%b we=%b mask=%b wd=%h addr=%h, expected 1 1 0011 deadbeef 00000200",
                         mem_en, mem_we, mem_wmask, mem_wdata, mem_addr);
    end
    step();
    #1;
    n_cmp++;
    if ({mem_en, mem_we, mem_wmask} !== '0) begin
      n_fail++; $display("FAIL st_wait: got en=%b we=%b mask=%b, expected 0 0 0000", mem_en, mem_we, mem_wmask);
    end
    step();
    #1;
    n_cmp++;
    if (d_resp_valid !== 1'b1) begin
      n_fail++; $display("FAIL st_ack: got %b, expected 1", d_resp_valid);
    end else begin
      exp = sb_d.pop_front();
      n_cmp++;
      if (d_rdata !== exp) begin
        n_fail++; $display("FAIL st_rdata: got %h, expected %h", d_rdata, exp);
      end
    end
    step();
    d_req_valid = 1'b1; d_addr = 32'h200;
    #1;
    n_cmp++;
    if (d_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL st_rb_ready: got %b, expected 1", d_req_ready);
    end
    sb_d.push_back(ref_mem[idx(32'h200)]);
    step();
    d_req_valid = 1'b0;
    #1;
    n_cmp++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0) begin
      n_fail++; $display("FAIL st_rb_issue: got en=%b we=%b, expected 1 0", mem_en, mem_we);
    end
    step();
    step();
    #1;
    n_cmp++;
    if (d_resp_valid !== 1'b1) begin
      n_fail++; $display("FAIL st_rb_resp: got %b, expected 1", d_resp_valid);
    end else begin
      exp = sb_d.pop_front();
      n_cmp++;
      if (d_rdata !== exp) begin
        n_fail++; $display("FAIL st_rb_rdata: got %h, expected %h", d_rdata, exp);
      end
    end
    step();
  endtask

  task automatic test_flush();
    logic [DW-1:0] exp;
    logic seen;
    step();
    if_req_valid = 1'b1; if_addr = 32'h104;
    #1;
    n_cmp++;
    if (if_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL fl_ready: got %b, expected 1", if_req_ready);
    end
    step();
    if_req_valid = 1'b0;
    step();
    if_flush = 1'b1;
    #1;
    n_cmp++;
    if (if_resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL fl_t2: got rv=%b, expected 0", if_resp_valid);
    end
    step();
    if_flush = 1'b0;
    #1;
    n_cmp++;
    if (if_resp_valid !== 1'b0 || if_rdata !== last_if) begin
      n_fail++; $display("FAIL fl_suppress: got rv=%b rdata=%h, expected 0 %h", if_resp_valid, if_rdata, last_if);
    end
    step();
    if_req_valid = 1'b1; if_addr = 32'h100;
    #1;
    n_cmp++;
    if (if_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL fl_idle_t4: got ifrdy=%b, expected 1", if_req_ready);
    end
    sb_if.push_back(ref_mem[idx(32'h100)]);
    step();
    if_req_valid = 1'b0;
    step();
    step();
    #1;
    n_cmp++;
    if (if_resp_valid !== 1'b1) begin
      n_fail++; $display("FAIL fl_next_resp: got %b, expected 1", if_resp_valid);
    end else begin
      exp = sb_if.pop_front();
      n_cmp++;
      if (if_rdata !== exp) begin
        n_fail++; $display("FAIL fl_next_rdata: got %h, expected %h", if_rdata, exp);
      end
      last_if = exp;
    end
    // flush coincident with the accept
    step();
    if_req_valid = 1'b1; if_addr = 32'h300; if_flush = 1'b1;
    #1;
    n_cmp++;
    if (if_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL fl_acc_ready: got %b, expected 1", if_req_ready);
    end
    step();
    if_req_valid = 1'b0; if_flush = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (if_resp_valid !== 1'b0) seen = 1'b1;
      step();
    end
    n_cmp++;
    if (seen) begin
      n_fail++; $display("FAIL fl_acc_suppress: got if_resp_valid pulse, expected none");
    end
    // flush must not touch a data load
    d_req_valid = 1'b1; d_we = 1'b0; d_addr = 32'h404;
    #1;
    n_cmp++;
    if (d_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL fl_d_ready: got %b, expected 1", d_req_ready);
    end
    sb_d.push_back(ref_mem[idx(32'h404)]);
    step();
    d_req_valid = 1'b0; if_flush = 1'b1;
    step();
    step();
    #1;
    n_cmp++;
    if (d_resp_valid !== 1'b1) begin
      n_fail++; $display("FAIL fl_d_resp: got %b, expected 1", d_resp_valid);
    end else begin
      exp = sb_d.pop_front();
      n_cmp++;
      if (d_rdata !== exp) begin
        n_fail++; $display("FAIL fl_d_rdata: got %h, expected %h", d_rdata, exp);
      end
    end
    if_flush = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] exp;
    logic seen;
    step();
    if_req_valid = 1'b1; if_addr = 32'h100;
    #1;
    n_cmp++;
    if (if_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL rm_ready: got %b, expected 1", if_req_ready);
    end
    step();
    if_req_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({if_req_ready, d_req_ready, mem_en, mem_we, mem_wmask, if_resp_valid, d_resp_valid} !== '0 ||
        {mem_addr, mem_wdata, if_rdata, d_rdata} !== '0) begin
      n_fail++; $display("FAIL rm_outputs: got en=%b addr=%h ifr=%h dr=%h rv=%b%b, expected all 0",
                         mem_en, mem_addr, if_rdata, d_rdata, if_resp_valid, d_resp_valid);
    end
    step();
    step();
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      #1;
      if (if_resp_valid !== 1'b0 || d_resp_valid !== 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin
      n_fail++; $display("FAIL rm_no_resp: got a resp pulse after reset, expected none");
    end
    step();
    if_req_valid = 1'b1; if_addr = 32'h300;
    #1;
    n_cmp++;
    if (if_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL rm_next_ready: got %b, expected 1", if_req_ready);
    end
    sb_if.push_back(ref_mem[idx(32'h300)]);
    step();
    if_req_valid = 1'b0;
    #1;
    n_cmp++;
    if (mem_en !== 1'b1 || mem_addr !== 32'h300) begin
      n_fail++; $display("FAIL rm_next_issue: got en=%b addr=%h, expected 1 00000300", mem_en, mem_addr);
    end
    step();
    step();
    #1;
    n_cmp++;
    if (if_resp_valid !== 1'b1) begin
      n_fail++; $display("FAIL rm_next_resp: got %b, expected 1", if_resp_valid);
    end else begin
      exp = sb_if.pop_front();
      n_cmp++;
      if (if_rdata !== exp) begin
        n_fail++; $display("FAIL rm_next_rdata: got %h, expected %h", if_rdata, exp);
      end
    end
    step();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
    last_if = '0;
    test_reset();
    test_fetch_only();
    test_both_valid();
    test_starvation();
    test_store();
    test_flush();
    test_reset_mid();
    n_cmp++;
    if (sb_if.size() != 0 || sb_d.size() != 0) begin
      n_fail++; $display("FAIL sb_drain: got %0d fetch / %0d data pending, expected 0 / 0", sb_if.size(), sb_d.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch requester (read-only) and the data-access requester (load/store).
- Sits between the fetch/memory pipeline stages and the memory macro.
- Grants one transaction at a time using valid/ready handshakes, sequences the memory access over a fixed latency, and routes the response back to the owner.
- Data port has priority; fetch is protected from starvation.

Parameters:
- AW, 32, address width
- DW, 32, data width; byte-mask width is DW/8
- LAT, 1, memory read latency in cycles, legal range 1..4
- STARVE_MAX, 4, maximum consecutive data grants while fetch waits, range 1..15

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- if_req_valid  in  1  fetch request valid
- if_req_ready  out  1  fetch request accepted this cycle when valid and ready are both high
- if_addr  in  AW  fetch address
- if_flush  in  1  drop any outstanding fetch response
- if_resp_valid  out  1  one-cycle pulse, fetch data valid
- if_rdata  out  DW  fetch read data
- d_req_valid  in  1  data request valid
- d_req_ready  out  1  data request accepted
- d_we  in  1  1 = store, 0 = load
- d_wmask  in  DW/8  store byte mask
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_resp_valid  out  1  one-cycle pulse: load data valid, or store done
- d_rdata  out  DW  load data; 0 for stores
- mem_en  out  1  memory access strobe, one cycle per transaction
- mem_we  out  1  memory write enable
- mem_wmask  out  DW/8  memory byte mask
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid LAT cycles after the mem_en cycle

Behaviour:
- Reset: asynchronous, active-high.
  - State goes to IDLE.
  - All outputs are 0; rdata registers, owner and starvation counter are cleared.
  - Reset mid-transaction abandons it; no resp_valid is issued afterwards.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - Ready outputs are high only in IDLE, and only toward the selected winner. Ready is combinational from the valids and the starvation counter.
  - IDLE: on accept at cycle T, latch owner, addr, we, wmask and wdata, then go to ISSUE. With no valid request, stay in IDLE.
  - ISSUE (cycle T+1): mem_en=1 and the mem_* outputs are driven from the latched values. Go to WAIT with the latency counter = LAT-1.
  - WAIT: count down. At count 0, register mem_rdata into the owner's rdata register and go to RESP.
  - RESP (cycle T+LAT+2): pulse the owner's resp_valid for one cycle, then return to IDLE. The next accept is possible at T+LAT+3.
- mem_en is 0 in all states except ISSUE. When mem_en is 0, mem_we and mem_wmask are 0.
- Stores run the same sequence. d_resp_valid is the store acknowledge and d_rdata=0 for a store.
- rdata outputs hold their last value between responses.
- Arbitration:
  - If only one valid is high, that requester wins.
  - If both are high, data wins unless starve_cnt == STARVE_MAX, in which case fetch wins.
  - starve_cnt increments on each data grant made while if_req_valid is high, and saturates at STARVE_MAX.
  - starve_cnt clears on any fetch grant.
- Flush:
  - if_flush high in any cycle while a fetch transaction is in ISSUE, WAIT or RESP marks it cancelled. Its if_resp_valid is suppressed and the FSM still completes the sequence.
  - if_flush in the same cycle as a fetch accept cancels that transaction.
  - if_flush has no effect on data transactions.
- Requesters must hold address and data stable while valid is high and not yet accepted.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- When defined, three 32-bit output ports are added:
  - perf_if_grants: fetch grants
  - perf_d_grants: data grants
  - perf_conflicts: cycles in IDLE with both valids high
- The counters wrap at 2^32 and clear on rst.
- When not defined, these ports and their registers do not exist.

Test Plan:
- Fetch only: if_req_valid=1, if_addr=0x100, mem_rdata=0x00000013, LAT=1 -> if_req_ready high at T, mem_en=1 with mem_addr=0x100 at T+1, if_resp_valid and if_rdata=0x00000013 at T+3.
- Both requesters valid, d_we=0, d_addr=0x200 -> data granted first; fetch granted at T+4; no overlap of mem_en.
- Data request held continuously with fetch waiting, STARVE_MAX=4 -> 4 data grants, then a fetch grant, then starve_cnt returns to 0.
- Store: d_we=1, d_wmask=4'b0011, d_wdata=0xDEADBEEF -> mem_we=1 and mem_wmask=4'b0011 only in ISSUE; d_resp_valid pulse with d_rdata=0.
- Fetch accepted, if_flush=1 at T+2 -> no if_resp_valid; FSM returns to IDLE at T+4; next fetch is served normally.
- Reset asserted in WAIT -> all outputs 0 immediately; no resp pulse after release; next request served with the standard latency.
